// File: rtl/slice_alu_pkg.sv
// Shared ALU operation encodings and small decode helpers for the sliced ALU.
package slice_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6
    } alu_op_e;

    // Ops that run the adder as a + ~b + 1.
    function automatic logic op_is_sub(input alu_op_e op);
        logic r;
        case (op)
            ALU_SUB, ALU_SLT, ALU_SLTU: r = 1'b1;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_is_cmp(input alu_op_e op);
        logic r;
        case (op)
            ALU_SLT, ALU_SLTU: r = 1'b1;
            default:           r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/slice_alu_adder.sv
// SLICE-bit adder with carry in/out; also exposes the carry into the MSB for overflow.
module slice_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         msb_cin
);

    logic [W:0] total_s;

    // Widened add so the carry-out lands in the top bit.
    always_comb begin
        total_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        sum     = total_s[W-1:0];
        cout    = total_s[W];
        msb_cin = a[W-1] ^ b[W-1] ^ total_s[W-1];
    end

endmodule

// File: rtl/slice_alu.sv
// Multi-cycle integer ALU processing one SLICE-bit chunk per clock, LSB first,
// with valid/ready handshakes on request and result sides.
module slice_alu
    import slice_alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SLICE = 8,
    parameter int IMM_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  alu_op_e           op,
    input  logic              use_imm,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic [IMM_W-1:0]  imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic              zero
);

    localparam int NSLICE = XLEN / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((SLICE < 1) || ((XLEN % SLICE) != 0) || ((SLICE & (SLICE - 1)) != 0)) begin : g_bad_cfg
        $fatal(1, "slice_alu: SLICE must be a power of two that divides XLEN");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } slice_alu_state_e;

    slice_alu_state_e  state_r;
    alu_op_e           op_r;
    logic [XLEN-1:0]   a_r;
    logic [XLEN-1:0]   b_r;
    logic [XLEN-1:0]   res_r;
    logic              carry_r;
    logic [IDX_W-1:0]  idx_r;

    logic [XLEN-1:0]   b_eff_s;
    logic [SLICE-1:0]  a_sl_s;
    logic [SLICE-1:0]  b_sl_s;
    logic [SLICE-1:0]  b_add_s;
    logic [SLICE-1:0]  sum_s;
    logic [SLICE-1:0]  slice_res_s;
    logic              cout_s;
    logic              msb_cin_s;
    logic              last_s;
    logic              lt_s;

    // Operand B selection at accept time: register or sign-extended immediate.
    always_comb begin
        if (use_imm) begin
            b_eff_s = {{(XLEN - IMM_W){imm[IMM_W-1]}}, imm};
        end else begin
            b_eff_s = b;
        end
    end

    // Current-slice operand extraction and per-op slice result.
    always_comb begin
        a_sl_s  = a_r[idx_r * SLICE +: SLICE];
        b_sl_s  = b_r[idx_r * SLICE +: SLICE];
        b_add_s = op_is_sub(op_r) ? ~b_sl_s : b_sl_s;
        last_s  = (idx_r == IDX_W'(NSLICE - 1));
        case (op_r)
            ALU_ADD, ALU_SUB,
            ALU_SLT, ALU_SLTU: slice_res_s = sum_s;
            ALU_AND:           slice_res_s = a_sl_s & b_sl_s;
            ALU_OR:            slice_res_s = a_sl_s | b_sl_s;
            ALU_XOR:           slice_res_s = a_sl_s ^ b_sl_s;
            default:           slice_res_s = {SLICE{1'b0}};
        endcase
        // On the top slice, sum MSB is the difference sign; msb_cin^cout is signed overflow.
        if (op_r == ALU_SLTU) begin
            lt_s = ~cout_s;
        end else begin
            lt_s = sum_s[SLICE-1] ^ (msb_cin_s ^ cout_s);
        end
    end

    slice_adder #(
        .W (SLICE)
    ) u_adder (
        .a       (a_sl_s),
        .b       (b_add_s),
        .cin     (carry_r),
        .sum     (sum_s),
        .cout    (cout_s),
        .msb_cin (msb_cin_s)
    );

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            op_r    <= ALU_ADD;
            a_r     <= {XLEN{1'b0}};
            b_r     <= {XLEN{1'b0}};
            res_r   <= {XLEN{1'b0}};
            carry_r <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r    <= op;
                        a_r     <= a;
                        b_r     <= b_eff_s;
                        idx_r   <= {IDX_W{1'b0}};
                        carry_r <= op_is_sub(op);
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    carry_r <= cout_s;
                    idx_r   <= idx_r + IDX_W'(1);
                    if (last_s && op_is_cmp(op_r)) begin
                        res_r <= {{(XLEN - 1){1'b0}}, lt_s};
                    end else begin
                        res_r[idx_r * SLICE +: SLICE] <= slice_res_s;
                    end
                    if (last_s) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign result    = res_r;
    assign zero      = (res_r == {XLEN{1'b0}});

endmodule

// File: tb/tb_slice_alu.sv
// Self-checking bench: four slice_alu instances (SLICE 8, 1, 4, 32) driven with
// directed and random transactions against an arithmetic reference model.
module tb_slice_alu;
    import slice_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    alu_op_e     op;
    logic        use_imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [11:0] imm;

    logic        in_valid_v  [4];
    logic        out_ready_v [4];
    logic        in_ready_v  [4];
    logic        out_valid_v [4];
    logic        zero_v      [4];
    logic [31:0] result_v    [4];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int SL = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32;
        slice_alu #(.XLEN(32), .SLICE(SL), .IMM_W(12)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .op        (op),
            .use_imm   (use_imm),
            .a         (a),
            .b         (b),
            .imm       (imm),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .result    (result_v[g]),
            .zero      (zero_v[g])
        );
    end

    function automatic int nsl(input int k);
        case (k)
            0:       return 4;
            1:       return 32;
            2:       return 8;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] model(input alu_op_e o, input logic [31:0] av,
                                          input logic [31:0] bv, input logic [11:0] iv,
                                          input logic ui);
        logic [31:0] bb;
        bb = ui ? 32'($signed(iv)) : bv;
        case (o)
            ALU_ADD:  return av + bb;
            ALU_SUB:  return av - bb;
            ALU_AND:  return av & bb;
            ALU_OR:   return av | bb;
            ALU_XOR:  return av ^ bb;
            ALU_SLT:  return ($signed(av) < $signed(bb)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (av < bb) ? 32'd1 : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // hold<0: out_ready raised in advance; hold>=0: stall that many cycles in DONE.
    task automatic txn(input int k, input alu_op_e o, input logic [31:0] av,
                       input logic [31:0] bv, input logic [11:0] iv, input logic ui,
                       input int hold, input string tag);
        logic [31:0] exp;
        int cyc;
        exp = model(o, av, bv, iv, ui);
        op = o; a = av; b = bv; imm = iv; use_imm = ui;
        in_valid_v[k]  = 1'b1;
        out_ready_v[k] = (hold < 0);
        chk({tag, ":accept_ready"}, 64'(in_ready_v[k]), 64'd1);
        step();
        in_valid_v[k] = 1'b0;
        a = $urandom; b = $urandom; imm = 12'($urandom); op = ALU_XOR; use_imm = ~ui;
        cyc = 0;
        while (!out_valid_v[k] && cyc < 200) begin
            step();
            cyc++;
        end
        chk({tag, ":latency"}, 64'(cyc), 64'(nsl(k)));
        chk({tag, ":result"}, 64'(result_v[k]), 64'(exp));
        chk({tag, ":zero"}, 64'(zero_v[k]), 64'(exp == 32'd0));
        chk({tag, ":busy"}, 64'(in_ready_v[k]), 64'd0);
        for (int h = 0; h < hold; h++) begin
            step();
            chk({tag, ":hold"}, {30'd0, out_valid_v[k], in_ready_v[k], result_v[k]},
                {30'd0, 1'b1, 1'b0, exp});
        end
        out_ready_v[k] = 1'b1;
        step();
        out_ready_v[k] = 1'b0;
        chk({tag, ":release"}, {62'd0, out_valid_v[k], in_ready_v[k]}, {62'd0, 1'b0, 1'b1});
    endtask

    initial begin
        logic [3:0] raw;
        logic       seen;
        rst_n = 1'b0;
        op = ALU_ADD; use_imm = 1'b0; a = 32'd0; b = 32'd0; imm = 12'd0;
        for (int k = 0; k < 4; k++) begin
            in_valid_v[k]  = 1'b0;
            out_ready_v[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset%0d", k),
                {29'd0, in_ready_v[k], out_valid_v[k], zero_v[k], result_v[k]},
                {29'd0, 1'b1, 1'b0, 1'b1, 32'd0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();

        txn(0, ALU_AND,  32'h0000_0001, 32'h0, 12'h0ff, 1'b1, 0, "and_imm1");
        txn(0, ALU_AND,  32'h0000_00ff, 32'h0, 12'h0ff, 1'b1, 0, "and_imm2");
        txn(0, ALU_OR,   32'h0000_0000, 32'h0, 12'hfff, 1'b1, 0, "or_sext");
        txn(0, ALU_AND,  32'h1234_5678, 32'h0, 12'h800, 1'b1, 0, "and_sext");
        txn(0, ALU_SUB,  32'h0000_0100, 32'h1, 12'h000, 1'b0, 0, "sub_borrow");
        txn(0, ALU_ADD,  32'h0000_00ff, 32'h1, 12'h000, 1'b0, 0, "add_carry");
        txn(0, ALU_ADD,  32'hffff_ffff, 32'h1, 12'h000, 1'b0, 0, "add_wrap");
        txn(0, ALU_SLT,  32'hffff_ffff, 32'h1, 12'h000, 1'b0, 0, "slt_neg");
        txn(0, ALU_SLTU, 32'hffff_ffff, 32'h1, 12'h000, 1'b0, 0, "sltu_big");
        txn(0, ALU_SLT,  32'h8000_0000, 32'h7fff_ffff, 12'h000, 1'b0, 0, "slt_ovf");
        txn(0, ALU_XOR,  32'hdead_beef, 32'h1234_5678, 12'h000, 1'b0, 5, "backpressure");
        txn(0, ALU_SUB,  32'h0000_0005, 32'h0, 12'h7ff, 1'b1, -1, "back_to_back");
        raw = 4'd9;
        txn(0, alu_op_e'(raw), 32'hffff_ffff, 32'h1, 12'h000, 1'b0, 0, "unsupported");

        // Abort a transaction mid-RUN with an asynchronous reset.
        op = ALU_ADD; a = 32'h1111_1111; b = 32'h2222_2222; use_imm = 1'b0;
        in_valid_v[0] = 1'b1;
        step();
        in_valid_v[0] = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset", {29'd0, in_ready_v[0], out_valid_v[0], zero_v[0], result_v[0]},
            {29'd0, 1'b1, 1'b0, 1'b1, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen = seen | out_valid_v[0];
        end
        chk("no_valid_after_reset", 64'(seen), 64'd0);
        txn(0, ALU_ADD, 32'h1111_1111, 32'h2222_2222, 12'h000, 1'b0, 0, "after_reset");

        for (int k = 1; k < 4; k++) begin
            txn(k, ALU_ADD, 32'h0000_00ff, 32'h1, 12'h000, 1'b0, 0, $sformatf("add_carry_i%0d", k));
            txn(k, ALU_ADD, 32'hffff_ffff, 32'h1, 12'h000, 1'b0, 0, $sformatf("add_wrap_i%0d", k));
            txn(k, ALU_SUB, 32'h0000_0100, 32'h1, 12'h000, 1'b0, 0, $sformatf("sub_i%0d", k));
            txn(k, ALU_SUB, 32'h0000_0000, 32'h1, 12'h000, 1'b0, 2, $sformatf("sub_neg_i%0d", k));
            txn(k, ALU_AND, 32'h1234_5678, 32'h0, 12'h800, 1'b1, 0, $sformatf("and_sext_i%0d", k));
            txn(k, ALU_SLT, 32'h8000_0000, 32'h7fff_ffff, 12'h000, 1'b0, -1, $sformatf("slt_ovf_i%0d", k));
        end

        for (int i = 0; i < 60; i++) begin
            int k;
            int hold;
            k    = int'($urandom_range(0, 3));
            raw  = 4'($urandom_range(0, 8));
            hold = int'($urandom_range(0, 3)) - 1;
            txn(k, alu_op_e'(raw), $urandom, $urandom, 12'($urandom), 1'($urandom),
                hold, $sformatf("rand%0d_i%0d_op%0d", i, k, raw));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/slice_alu.md
# slice_alu

Parametrised multi-cycle ALU executing register-register and register-immediate integer ops (ADD, SUB, AND, OR, XOR, SLT, SLTU) one SLICE-bit chunk per clock, LSB first. Successor to the single-cycle ALU used by the multi-cycle RISC-V core: generalised in datapath width and slice width, with native I-type immediate sign-extension and a valid/ready handshake on both sides. Intended for area-constrained core variants where the execute stage may stall.

## Interface
- XLEN, 32: operand/result width.
- SLICE, 8: bits processed per cycle; power of two, divides XLEN; NSLICE = XLEN/SLICE.
- IMM_W, 12: immediate width, sign-extended to XLEN.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low (fixed decision).
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- op  in  alu_op_e  operation (shared enum).
- use_imm  in  1  1: operand B = sext(imm); 0: operand B = b.
- a  in  XLEN  operand A.
- b  in  XLEN  operand B (register).
- imm  in  IMM_W  immediate.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  result.
- zero  out  1  result == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch op, a, effective B (mux on use_imm), slice index=0, carry=1 for SUB/SLT/SLTU else 0; go RUN.
- RUN: each cycle processes slice i: ADD -> a_i+b_i+carry; SUB/SLT/SLTU -> a_i+~b_i+carry; AND/OR/XOR bitwise. Write slice i of result register, update carry, i++. After slice NSLICE-1, go DONE.
- SLT/SLTU final step (entering DONE): result = {XLEN-1 zeros, lt}; SLTU lt = ~carry_out; SLT lt = diff[XLEN-1] ^ overflow, overflow = (a[XLEN-1]!=b[XLEN-1]) && (diff[XLEN-1]!=a[XLEN-1]).
- Arithmetic is modulo 2^XLEN; carry-out discarded for ADD/SUB.
- Unsupported op value: runs full latency, result = 0.
- DONE: out_valid=1, result/zero stable. On out_ready go IDLE. No accept in DONE (in_ready=0).
- Inputs ignored outside the accept cycle; changes during RUN/DONE have no effect.

## Timing
- Reset (asserted, asynchronous): state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, carry=0, index=0.
- Reset mid-RUN or mid-DONE: transaction discarded, outputs to reset values immediately; no out_valid pulse after release.
- Latency: accept at edge T -> out_valid high after edge T+NSLICE (32/8: 4 RUN cycles).
- Minimum initiation interval: NSLICE+2 cycles (RUN x NSLICE, DONE >=1, IDLE 1).
- out_valid held with result unchanged until out_ready sampled high; out_ready may be high in advance (DONE lasts exactly one cycle).
- zero is combinational from the result register; meaningful only when out_valid=1.
- NSLICE=1 legal: single RUN cycle.

## Structure
- alu_op_e and shared op encodings stay in the existing ALU header/package; add localparam helpers (NSLICE, slice index width $clog2(NSLICE) min 1) in the module.
- State enum slice_alu_state_e local to the module.
- One natural sub-module: slice_adder (SLICE-bit add with carry-in/out, also returns MSB carry-in for overflow).
- Elaboration-time assertion: XLEN % SLICE == 0, SLICE power of two.

## Test plan
- AND imm: a=0x01, use_imm=1, imm=0x0ff -> result 0x00000001, zero=0 after 4 RUN cycles; a=0xff, imm=0x0ff -> 0x000000ff.
- Imm sign-extension: OR a=0x00000000, imm=0xfff -> 0xffffffff; AND a=0x12345678, imm=0x800 -> 0x12345000.
- Carry across slices: SUB a=0x00000100, b=0x00000001 -> 0x000000ff; ADD a=0x000000ff, b=0x1 -> 0x00000100; ADD 0xffffffff+1 -> 0, zero=1.
- Compare: SLT a=0xffffffff, b=1 -> 1; SLTU same -> 0; SLT a=0x80000000, b=0x7fffffff -> 1 (overflow path).
- Backpressure: out_ready=0 for 5 cycles -> out_valid and result held, in_ready=0; out_ready=1 -> IDLE next cycle, back-to-back request accepted.
- Reset mid-RUN (after slice 2): all outputs reset immediately, no out_valid after release; repeat ADD/SUB/AND suite with SLICE=1, 4, 32.
